// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - shared memory command port between the arbiter and the memory interface
interface mem_port_arbiter_if;
    logic        mem_read;
    logic        mem_write;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;
    logic        mem_stall;

    // The arbiter issues commands; the memory side returns data and stall.
    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        output mem_byte_en,
        input  mem_rdata,
        input  mem_stall
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        input  mem_byte_en,
        output mem_rdata,
        output mem_stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - I-cache / D-cache arbiter for the single memory command port
module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic               ui_clk,
    input  logic               rst,
    input  logic               ic_req,
    input  logic [29:0]        ic_addr,
    output logic               ic_done,
    output logic [31:0]        ic_rdata,
    input  logic               dc_req,
    input  logic               dc_we,
    input  logic [29:0]        dc_addr,
    input  logic [31:0]        dc_wdata,
    input  logic [3:0]         dc_byte_en,
    output logic               dc_done,
    output logic [31:0]        dc_rdata,
    mem_port_arbiter_if.master mem,
    output logic               busy,
    output logic               timeout_err
);
    localparam int unsigned         STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_XFER = 2'd1,
        D_XFER = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] d_streak;
    logic [15:0]         xfer_cnt;
    logic                xfer_we;
    logic                i_wins;
    logic                xfer_complete;

    // D normally wins; once D has taken MAX_D_STREAK grants in a row over a waiting I, I goes next.
    assign i_wins = ic_req && ((d_streak == STREAK_MAX) || !dc_req);

    // xfer_cnt is zero only in the issue cycle, where the stall input is not yet meaningful.
    assign xfer_complete = (xfer_cnt != 16'd0) && !mem.mem_stall;

    assign busy = (state != IDLE);

    // Grant, hold the latched command until the memory side releases it, then pulse done once.
    always_ff @(posedge ui_clk) begin
        if (rst) begin
            state           <= IDLE;
            d_streak        <= '0;
            xfer_cnt        <= 16'd0;
            xfer_we         <= 1'b0;
            timeout_err     <= 1'b0;
            ic_done         <= 1'b0;
            dc_done         <= 1'b0;
            ic_rdata        <= 32'd0;
            dc_rdata        <= 32'd0;
            mem.mem_read    <= 1'b0;
            mem.mem_write   <= 1'b0;
            mem.mem_addr    <= 30'd0;
            mem.mem_wdata   <= 32'd0;
            mem.mem_byte_en <= 4'd0;
        end else begin
            ic_done <= 1'b0;
            dc_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_wins) begin
                        state           <= I_XFER;
                        mem.mem_read    <= 1'b1;
                        mem.mem_write   <= 1'b0;
                        mem.mem_addr    <= ic_addr;
                        mem.mem_byte_en <= 4'hF;
                        xfer_we         <= 1'b0;
                        xfer_cnt        <= 16'd0;
                        d_streak        <= '0;
                    end else if (dc_req) begin
                        state           <= D_XFER;
                        mem.mem_read    <= !dc_we;
                        mem.mem_write   <= dc_we;
                        mem.mem_addr    <= dc_addr;
                        mem.mem_wdata   <= dc_wdata;
                        mem.mem_byte_en <= dc_we ? dc_byte_en : 4'hF;
                        xfer_we         <= dc_we;
                        xfer_cnt        <= 16'd0;
                        // The streak only counts D grants that made a waiting I wait longer.
                        if (!ic_req) begin
                            d_streak <= '0;
                        end else if (d_streak != STREAK_MAX) begin
                            d_streak <= d_streak + 1'b1;
                        end
                    end
                end
                I_XFER, D_XFER: begin
                    if (xfer_cnt != TIMEOUT_CYCLES) begin
                        xfer_cnt <= xfer_cnt + 16'd1;
                    end
                    // Flag a hung memory port but keep waiting; the transfer is never abandoned.
                    if ((xfer_cnt + 16'd1) >= TIMEOUT_CYCLES) begin
                        timeout_err <= 1'b1;
                    end
                    if (xfer_complete) begin
                        state         <= DONE;
                        mem.mem_read  <= 1'b0;
                        mem.mem_write <= 1'b0;
                        if (state == I_XFER) begin
                            ic_done  <= 1'b1;
                            ic_rdata <= mem.mem_rdata;
                        end else begin
                            dc_done <= 1'b1;
                            if (!xfer_we) begin
                                dc_rdata <= mem.mem_rdata;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        ui_clk = 1'b0;
    logic        rst;
    logic        ic_req;
    logic [29:0] ic_addr;
    logic        ic_done;
    logic [31:0] ic_rdata;
    logic        dc_req;
    logic        dc_we;
    logic [29:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_byte_en;
    logic        dc_done;
    logic [31:0] dc_rdata;
    logic        busy;
    logic        timeout_err;

    mem_port_arbiter_if mem ();

    mem_port_arbiter #(
        .MAX_D_STREAK   (MAXS),
        .TIMEOUT_CYCLES (16'(TMO))
    ) dut (
        .ui_clk      (ui_clk),
        .rst         (rst),
        .ic_req      (ic_req),
        .ic_addr     (ic_addr),
        .ic_done     (ic_done),
        .ic_rdata    (ic_rdata),
        .dc_req      (dc_req),
        .dc_we       (dc_we),
        .dc_addr     (dc_addr),
        .dc_wdata    (dc_wdata),
        .dc_byte_en  (dc_byte_en),
        .dc_done     (dc_done),
        .dc_rdata    (dc_rdata),
        .mem         (mem),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 ui_clk = ~ui_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding command with its age, a pending done, a streak count.
    bit          m_valid = 1'b0;
    bit          m_active, m_is_d, m_we, m_done, m_done_d, m_tmo;
    logic [29:0] m_addr;
    logic [31:0] m_wdata, m_ic_rdata, m_dc_rdata;
    logic [3:0]  m_be;
    int          m_age, m_streak;
    bit          grant_log[$];

    initial begin
        forever begin
            @(negedge ui_clk);
            if (m_valid) begin
                chk1("mem_read", mem.mem_read, m_active && !(m_is_d && m_we));
                chk1("mem_write", mem.mem_write, m_active && m_is_d && m_we);
                chk1("busy", busy, m_active || m_done);
                chk1("ic_done", ic_done, m_done && !m_done_d);
                chk1("dc_done", dc_done, m_done && m_done_d);
                chk("ic_rdata", ic_rdata, m_ic_rdata);
                chk("dc_rdata", dc_rdata, m_dc_rdata);
                chk1("timeout_err", timeout_err, m_tmo);
                if (m_active) begin
                    chk("mem_addr", 32'(mem.mem_addr), 32'(m_addr));
                    chk("mem_byte_en", 32'(mem.mem_byte_en), 32'(m_be));
                    if (m_is_d) chk("mem_wdata", mem.mem_wdata, m_wdata);
                end
            end
            if (rst) begin
                m_valid    = 1'b1;
                m_active   = 1'b0;
                m_is_d     = 1'b0;
                m_we       = 1'b0;
                m_done     = 1'b0;
                m_done_d   = 1'b0;
                m_tmo      = 1'b0;
                m_age      = 0;
                m_streak   = 0;
                m_ic_rdata = 32'd0;
                m_dc_rdata = 32'd0;
                m_addr     = 30'd0;
                m_wdata    = 32'd0;
                m_be       = 4'd0;
            end else if (m_valid) begin
                if (m_active) begin
                    if (m_age >= 1 && !mem.mem_stall) begin
                        if (!m_is_d) m_ic_rdata = mem.mem_rdata;
                        else if (!m_we) m_dc_rdata = mem.mem_rdata;
                        m_active = 1'b0;
                        m_done   = 1'b1;
                        m_done_d = m_is_d;
                    end
                    m_age++;
                    if (m_age >= TMO) m_tmo = 1'b1;
                end else if (m_done) begin
                    m_done = 1'b0;
                end else if (ic_req && (m_streak == MAXS || !dc_req)) begin
                    m_active = 1'b1;
                    m_is_d   = 1'b0;
                    m_we     = 1'b0;
                    m_addr   = ic_addr;
                    m_be     = 4'hF;
                    m_age    = 0;
                    m_streak = 0;
                    grant_log.push_back(1'b0);
                end else if (dc_req) begin
                    m_active = 1'b1;
                    m_is_d   = 1'b1;
                    m_we     = dc_we;
                    m_addr   = dc_addr;
                    m_wdata  = dc_wdata;
                    m_be     = dc_we ? dc_byte_en : 4'hF;
                    m_age    = 0;
                    m_streak = ic_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
                    grant_log.push_back(1'b1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic idle_inputs();
        ic_req        = 1'b0;
        ic_addr       = 30'd0;
        dc_req        = 1'b0;
        dc_we         = 1'b0;
        dc_addr       = 30'd0;
        dc_wdata      = 32'd0;
        dc_byte_en    = 4'd0;
        mem.mem_stall = 1'b0;
        mem.mem_rdata = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk1(name, busy, 1'b0);
    endtask

    int          n_grants;
    int          dones;
    int          base;
    bit          prev_busy;
    logic [9:0]  order;
    logic [9:0]  m_order;
    logic [9:0]  exp_order;

    initial begin
        rst = 1'b1;
        idle_inputs();
        exp_order = 10'b11_1101_1110;

        // Reset state, then a single zero-stall D write
        do_reset();
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_mem_write", mem.mem_write, 1'b0);
        chk1("reset_mem_read", mem.mem_read, 1'b0);
        chk("reset_ic_rdata", ic_rdata, 32'd0);
        chk1("reset_timeout", timeout_err, 1'b0);
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 30'h1000; dc_wdata = 32'h1; dc_byte_en = 4'hF;
        tick();
        chk1("t1_c1_mem_write", mem.mem_write, 1'b1);
        chk("t1_c1_addr", 32'(mem.mem_addr), 32'h1000);
        chk("t1_c1_wdata", mem.mem_wdata, 32'h1);
        chk("t1_c1_be", 32'(mem.mem_byte_en), 32'hF);
        tick();
        chk1("t1_c2_mem_write", mem.mem_write, 1'b1);
        chk1("t1_c2_dc_done", dc_done, 1'b0);
        tick();
        chk1("t1_c3_dc_done", dc_done, 1'b1);
        chk1("t1_c3_mem_write", mem.mem_write, 1'b0);
        chk("t1_c3_dc_rdata", dc_rdata, 32'd0);
        dc_req = 1'b0; dc_we = 1'b0;
        tick();
        chk1("t1_c4_busy", busy, 1'b0);

        // I read held off by six stall cycles
        ic_req = 1'b1; ic_addr = 30'h20; mem.mem_stall = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) chk("t2_c1_addr", 32'(mem.mem_addr), 32'h20);
            if (c == 7) begin
                chk1("t2_c7_mem_read", mem.mem_read, 1'b1);
                chk1("t2_c7_ic_done", ic_done, 1'b0);
                mem.mem_stall = 1'b0;
                mem.mem_rdata = 32'hDEADBEEF;
            end
            if (c == 8) begin
                chk1("t2_c8_ic_done", ic_done, 1'b1);
                chk("t2_c8_ic_rdata", ic_rdata, 32'hDEADBEEF);
                chk1("t2_c8_mem_read", mem.mem_read, 1'b0);
                ic_req = 1'b0;
                mem.mem_rdata = 32'd0;
            end
        end
        tick();

        // Both requesters held high: starvation limit decides the order
        ic_addr = 30'h111; dc_addr = 30'h222; dc_we = 1'b0;
        ic_req = 1'b1; dc_req = 1'b1;
        n_grants = 0; order = '0; prev_busy = busy; base = grant_log.size();
        for (int c = 0; c < 80 && n_grants < 10; c++) begin
            tick();
            if (busy && !prev_busy) begin
                order = {order[8:0], (mem.mem_addr == 30'h222)};
                n_grants++;
            end
            prev_busy = busy;
        end
        chk("t3_grant_count", n_grants, 10);
        chk("t3_dut_order", 32'(order), 32'(exp_order));
        m_order = '0;
        for (int k = 0; k < 10; k++) begin
            if (base + k < grant_log.size()) m_order = {m_order[8:0], grant_log[base + k]};
        end
        chk("t3_model_order", 32'(m_order), 32'(exp_order));
        ic_req = 1'b0; dc_req = 1'b0;
        wait_idle("t3_idle");
        tick();

        // Address change and req drop mid-transfer are ignored
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 30'h3ABC; mem.mem_stall = 1'b1;
        dones = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (dc_done) dones++;
            if (c == 1) chk("t4_c1_addr", 32'(mem.mem_addr), 32'h3ABC);
            if (c == 2) begin
                dc_addr = 30'h1; dc_wdata = 32'h55; dc_req = 1'b0;
            end
            if (c == 4) begin
                chk("t4_c4_addr", 32'(mem.mem_addr), 32'h3ABC);
                chk1("t4_c4_mem_read", mem.mem_read, 1'b1);
                mem.mem_stall = 1'b0;
                mem.mem_rdata = 32'hCAFE0001;
            end
            if (c == 6) chk("t4_c6_dc_rdata", dc_rdata, 32'hCAFE0001);
        end
        chk("t4_done_pulses", dones, 1);

        // Reset in the middle of a stalled D write
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 30'h77; dc_wdata = 32'h12345678; dc_byte_en = 4'h3;
        mem.mem_stall = 1'b1;
        tick();
        tick();
        tick();
        chk1("t5_c3_mem_write", mem.mem_write, 1'b1);
        chk("t5_c3_be", 32'(mem.mem_byte_en), 32'h3);
        rst = 1'b1;
        tick();
        chk1("t5_c4_mem_write", mem.mem_write, 1'b0);
        chk1("t5_c4_busy", busy, 1'b0);
        chk1("t5_c4_dc_done", dc_done, 1'b0);
        rst = 1'b0; dc_req = 1'b0; mem.mem_stall = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk1("t5_no_dc_done", dc_done, 1'b0);
        end
        ic_req = 1'b1; ic_addr = 30'h99;
        tick();
        chk1("t5_new_mem_read", mem.mem_read, 1'b1);
        chk("t5_new_addr", 32'(mem.mem_addr), 32'h99);
        tick();
        tick();
        chk1("t5_new_ic_done", ic_done, 1'b1);
        ic_req = 1'b0;
        tick();

        // Randomized traffic, stalls, read data and occasional resets
        for (int c = 0; c < 2000; c++) begin
            if (ic_done) ic_req = 1'b0;
            else if (!ic_req && $urandom_range(0, 3) == 0) begin
                ic_req = 1'b1; ic_addr = 30'($urandom);
            end else if (ic_req && $urandom_range(0, 31) == 0) ic_req = 1'b0;
            else if (ic_req && $urandom_range(0, 15) == 0) ic_addr = 30'($urandom);

            if (dc_done) dc_req = 1'b0;
            else if (!dc_req && $urandom_range(0, 2) == 0) begin
                dc_req = 1'b1; dc_we = 1'($urandom); dc_addr = 30'($urandom);
                dc_wdata = $urandom; dc_byte_en = 4'($urandom);
            end else if (dc_req && $urandom_range(0, 31) == 0) dc_req = 1'b0;
            else if (dc_req && $urandom_range(0, 15) == 0) begin
                dc_addr = 30'($urandom); dc_wdata = $urandom; dc_we = 1'($urandom);
            end

            mem.mem_stall = ($urandom_range(0, 1) == 1);
            mem.mem_rdata = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        do_reset();

        // Stalled write that runs past the timeout threshold
        chk1("t6_tmo_clear", timeout_err, 1'b0);
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 30'h5; dc_wdata = 32'hA5A5; dc_byte_en = 4'hC;
        mem.mem_stall = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 8) chk1("t6_c8_tmo", timeout_err, 1'b0);
            if (c == 9) chk1("t6_c9_tmo", timeout_err, 1'b1);
            if (c == 13) begin
                chk1("t6_c13_mem_write", mem.mem_write, 1'b1);
                mem.mem_stall = 1'b0;
            end
            if (c == 14) begin
                chk1("t6_c14_dc_done", dc_done, 1'b1);
                dc_req = 1'b0;
            end
            if (c == 15) begin
                chk1("t6_c15_tmo", timeout_err, 1'b1);
                chk1("t6_c15_busy", busy, 1'b0);
            end
        end
        do_reset();
        chk1("t6_tmo_after_rst", timeout_err, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
